// File: rtl/eth_pkg.sv
// Shared types, framing constants and the CRC-32 helper for the Ethernet MAC transmit path.
package eth_pkg;

    typedef logic [2:0] tx_state_t;

    localparam tx_state_t ST_IDLE = 3'd0;
    localparam tx_state_t ST_DATA = 3'd1;
    localparam tx_state_t ST_PAD  = 3'd2;
    localparam tx_state_t ST_FCS  = 3'd3;
    localparam tx_state_t ST_GAP  = 3'd4;

    localparam int MIN_FRAME = 60;
    localparam int FCS_LEN   = 4;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    // Reflected CRC-32 advanced by one byte, LSB of the byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_mac_tx_if.sv
// User byte-stream handshake into the MAC transmitter.
interface eth_mac_tx_if;
    logic       s_valid;
    logic       s_ready;
    logic       s_last;
    logic [7:0] s_data;

    modport master (output s_valid, output s_last, output s_data, input s_ready);
    modport slave  (input s_valid, input s_last, input s_data, output s_ready);
endinterface

// File: rtl/eth_tx_frame_buffer.sv
// Store-and-forward byte buffer: each entry carries a last-byte flag so the reader
// can find frame boundaries; frames only become visible once completely written.
module eth_tx_frame_buffer
    import eth_pkg::*;
#(
    parameter int BUF_BYTES = 2048,
    parameter int MAX_LEN   = 1514
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_valid,
    input  logic       wr_last,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       frame_drop,
    output logic       rd_avail,
    output logic [7:0] rd_data,
    output logic       rd_last,
    input  logic       rd_pop
);

    localparam int AW = $clog2(BUF_BYTES);
    localparam int LW = $clog2(MAX_LEN + 2);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [8:0]    mem [BUF_BYTES];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   start_ptr_q, start_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   frames_q, frames_d;
    logic [AW:0]   used;
    logic [LW-1:0] len_q, len_d;
    logic          drop_q, drop_d;
    logic          alive_q;
    logic          wr_fire, over, mem_we, commit, frame_done;

    assign {rd_last, rd_data} = mem[rd_ptr_q[AW-1:0]];
    assign rd_avail = (frames_q != '0);

    // Write side accepts bytes, rewinds an oversize frame, and tracks complete frames.
    always_comb begin
        used        = wr_ptr_q - rd_ptr_q;
        wr_ready    = alive_q && !used[AW];
        wr_fire     = wr_valid && wr_ready;
        over        = drop_q || (len_q == LW'(MAX_LEN));
        wr_ptr_d    = wr_ptr_q;
        start_ptr_d = start_ptr_q;
        len_d       = len_q;
        drop_d      = drop_q;
        mem_we      = 1'b0;
        commit      = 1'b0;
        frame_drop  = 1'b0;
        if (wr_fire) begin
            if (over) begin
                wr_ptr_d   = start_ptr_q;
                len_d      = '0;
                drop_d     = !wr_last;
                frame_drop = wr_last;
            end else begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                len_d    = len_q + LW'(1);
                if (wr_last) begin
                    commit      = 1'b1;
                    start_ptr_d = wr_ptr_q + PTR_ONE;
                    len_d       = '0;
                end
            end
        end
        frame_done = rd_pop && rd_last;
        rd_ptr_d   = rd_pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        frames_d   = frames_q;
        if (commit && !frame_done) begin
            frames_d = frames_q + PTR_ONE;
        end else if (!commit && frame_done) begin
            frames_d = frames_q - PTR_ONE;
        end
    end

    // Buffer storage is written without reset; stale contents are never eligible.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q[AW-1:0]] <= {wr_last, wr_data};
        end
    end

    // Pointer and frame-count registers; reset discards everything buffered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            start_ptr_q <= '0;
            rd_ptr_q    <= '0;
            frames_q    <= '0;
            len_q       <= '0;
            drop_q      <= 1'b0;
            alive_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            start_ptr_q <= start_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            frames_q    <= frames_d;
            len_q       <= len_d;
            drop_q      <= drop_d;
            alive_q     <= 1'b1;
        end
    end

endmodule

// File: rtl/eth_mac_tx.sv
// Ethernet MAC transmitter: buffers whole frames, then streams data, pad, FCS and
// enforces the inter-frame gap toward the PCS.
module eth_mac_tx
    import eth_pkg::*;
#(
    parameter int BUF_BYTES = 2048,
    parameter int MAX_LEN   = 1514,
    parameter int IFG       = 12
) (
    input  logic        clk,
    input  logic        reset_n,
    eth_mac_tx_if.slave s,
    input  logic        eth_ready,
    input  logic        ready_in,
    output logic        sof_in,
    output logic        eof_in,
    output logic [7:0]  data_in,
    output logic        tx_busy,
    output logic        frame_drop
);

    localparam int CW = $clog2(MAX_LEN + 2);
    localparam int GW = (IFG > 1) ? $clog2(IFG + 1) : 1;

    tx_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0] crc_q, crc_d, crc_fin;
    logic [1:0]  fcs_idx_q, fcs_idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic        rd_avail, rd_last, rd_pop;
    logic [7:0]  rd_data;

    eth_tx_frame_buffer #(
        .BUF_BYTES (BUF_BYTES),
        .MAX_LEN   (MAX_LEN)
    ) u_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_valid   (s.s_valid),
        .wr_last    (s.s_last),
        .wr_data    (s.s_data),
        .wr_ready   (s.s_ready),
        .frame_drop (frame_drop),
        .rd_avail   (rd_avail),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .rd_pop     (rd_pop)
    );

    assign tx_busy = (state_q != ST_IDLE);

    // Transmit sequencer: once started, a byte leaves every cycle until the last FCS byte.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        fcs_idx_d = fcs_idx_q;
        gap_d     = gap_q;
        rd_pop    = 1'b0;
        sof_in    = 1'b0;
        eof_in    = 1'b0;
        data_in   = 8'h00;
        cnt_inc   = cnt_q + CW'(1);
        crc_fin   = ~crc_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_avail && eth_ready && ready_in) begin
                    sof_in    = 1'b1;
                    data_in   = rd_data;
                    rd_pop    = 1'b1;
                    crc_d     = crc32_byte(CRC_INIT, rd_data);
                    cnt_d     = CW'(1);
                    fcs_idx_d = 2'd0;
                    if (rd_last) begin
                        state_d = (CW'(1) < CW'(MIN_FRAME)) ? ST_PAD : ST_FCS;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                data_in = rd_data;
                rd_pop  = 1'b1;
                crc_d   = crc32_byte(crc_q, rd_data);
                cnt_d   = cnt_inc;
                if (rd_last) begin
                    state_d = (cnt_inc < CW'(MIN_FRAME)) ? ST_PAD : ST_FCS;
                end
            end
            ST_PAD: begin
                crc_d = crc32_byte(crc_q, 8'h00);
                cnt_d = cnt_inc;
                if (cnt_inc == CW'(MIN_FRAME)) begin
                    state_d = ST_FCS;
                end
            end
            ST_FCS: begin
                data_in   = crc_fin[{fcs_idx_q, 3'b000} +: 8];
                fcs_idx_d = fcs_idx_q + 2'd1;
                if (fcs_idx_q == 2'(FCS_LEN - 1)) begin
                    eof_in  = 1'b1;
                    gap_d   = '0;
                    crc_d   = CRC_INIT;
                    state_d = (IFG == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GW'(IFG - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            crc_q     <= CRC_INIT;
            fcs_idx_q <= 2'd0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            fcs_idx_q <= fcs_idx_d;
            gap_q     <= gap_d;
        end
    end

endmodule

// File: tb/tb_eth_mac_tx.sv
// Self-checking bench for eth_mac_tx: frame table, hand-written corner sequences
// and a randomized run, all compared against a frame-level reference model.
module tb_eth_mac_tx;

    localparam int MAX_LEN = 1514;
    localparam int IFG     = 12;
    localparam int MINF    = 60;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    typedef struct {
        int len;
        bit gaps;
        int exp_wire_len;
        bit exp_drop;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       eth_ready = 1'b0;
    logic       ready_in = 1'b0;
    logic       sof_in, eof_in, tx_busy, frame_drop;
    logic [7:0] data_in;

    int errors = 0;
    int checks = 0;
    int cycle = 0;

    logic [31:0] crc_tab [256];
    logic [7:0]  stim [$];
    logic [7:0]  exp_bytes [$];
    int          exp_lens [$];
    logic [7:0]  cur [$];
    logic [7:0]  last_rx [$];
    bit          in_frame = 1'b0;
    bit          prev_drop = 1'b0;
    bit          rand_ready = 1'b0;
    int          rx_frames = 0;
    int          drops_seen = 0;
    int          last_eof_cycle = -1000;
    int          last_gap = 0;

    eth_mac_tx_if u_if ();

    eth_mac_tx #(
        .BUF_BYTES (2048),
        .MAX_LEN   (MAX_LEN),
        .IFG       (IFG)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s          (u_if),
        .eth_ready  (eth_ready),
        .ready_in   (ready_in),
        .sof_in     (sof_in),
        .eof_in     (eof_in),
        .data_in    (data_in),
        .tx_busy    (tx_busy),
        .frame_drop (frame_drop)
    );

    // 125 MHz clock
    always #4 clk = ~clk;

    // Cycle counter used for gap measurements
    always @(posedge clk) cycle++;

    // Optional random ready_in pattern from the PCS
    always @(posedge clk) begin
        if (rand_ready) begin
            #1 ready_in = ($urandom_range(1) == 1);
        end
    end

    task automatic check_output(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] b);
        return crc_tab[c[7:0] ^ b] ^ (c >> 8);
    endfunction

    // Reference model: pad to minimum, append complemented CRC LSB first, or count a drop.
    task automatic model_push();
        logic [31:0] c;
        logic [7:0]  v;
        int          n;
        if (stim.size() > MAX_LEN) return;
        c = 32'hFFFFFFFF;
        n = (stim.size() < MINF) ? MINF : stim.size();
        for (int k = 0; k < n; k++) begin
            v = (k < stim.size()) ? stim[k] : 8'h00;
            exp_bytes.push_back(v);
            c = ref_crc(c, v);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) exp_bytes.push_back(c[8*k +: 8]);
        exp_lens.push_back(n + 4);
    endtask

    task automatic compare_frame();
        int n;
        int mism;
        last_rx = cur;
        if (exp_lens.size() == 0) begin
            check_output("unexpected_frame", cur.size(), 0);
            return;
        end
        n = exp_lens.pop_front();
        check_output("frame_len", cur.size(), n);
        mism = 0;
        for (int k = 0; k < n; k++) begin
            if (exp_bytes.size() != 0) begin
                if (k >= cur.size() || cur[k] !== exp_bytes[0]) mism++;
                void'(exp_bytes.pop_front());
            end
        end
        check_output("frame_bytes", mism, 0);
    endtask

    // PCS-side monitor: captures frames and checks start rules and idle output levels.
    always @(negedge clk) begin
        if (!reset_n) begin
            in_frame  = 1'b0;
            prev_drop = 1'b0;
            cur.delete();
        end else begin
            if (frame_drop) begin
                check_output("drop_single_pulse", prev_drop, 0);
                drops_seen++;
            end
            prev_drop = frame_drop;
            if (sof_in) begin
                last_gap = cycle - last_eof_cycle;
                check_output("sof_inside_frame", in_frame, 0);
                check_output("sof_needs_ready_in", ready_in, 1);
                check_output("sof_needs_eth_ready", eth_ready, 1);
                check_output("ifg_respected", (last_gap >= IFG + 1), 1);
                in_frame = 1'b1;
                cur.delete();
            end
            if (in_frame) begin
                cur.push_back(data_in);
                if (eof_in) begin
                    in_frame = 1'b0;
                    rx_frames++;
                    last_eof_cycle = cycle;
                    compare_frame();
                end
            end else begin
                check_output("idle_outputs_zero", {data_in, eof_in}, 0);
            end
        end
    end

    // Drives one user frame of random bytes, optionally with valid gaps.
    task automatic apply_stimulus(input int len, input bit gaps);
        int i;
        int guard;
        bit acc;
        stim.delete();
        for (int k = 0; k < len; k++) stim.push_back(8'($urandom_range(255)));
        model_push();
        i = 0;
        guard = 0;
        while (i < len && guard < 20000) begin
            if (gaps && $urandom_range(3) == 0) begin
                u_if.s_valid = 1'b0;
            end else begin
                u_if.s_valid = 1'b1;
                u_if.s_data  = stim[i];
                u_if.s_last  = (i == len - 1);
            end
            @(negedge clk);
            acc = u_if.s_valid && u_if.s_ready;
            @(posedge clk);
            #1;
            if (acc) i++;
            guard++;
        end
        u_if.s_valid = 1'b0;
        u_if.s_last  = 1'b0;
        check_output("send_complete", i, len);
    endtask

    task automatic wait_idle();
        int n;
        bit busy;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            busy = (exp_lens.size() != 0) || tx_busy || in_frame;
            n++;
        end while (busy && n < 20000);
        check_output("drain_done", busy, 0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] residue_of_last();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (last_rx[k]) c = ref_crc(c, last_rx[k]);
        return c;
    endfunction

    // Watchdog so the run always ends
    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs [9];
        int   f0, d0, nf, nd, len, n;
        logic [31:0] c;

        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[i] = c;
        end

        vecs[0] = '{len: 60,   gaps: 1'b0, exp_wire_len: 64,   exp_drop: 1'b0};
        vecs[1] = '{len: 14,   gaps: 1'b0, exp_wire_len: 64,   exp_drop: 1'b0};
        vecs[2] = '{len: 1,    gaps: 1'b0, exp_wire_len: 64,   exp_drop: 1'b0};
        vecs[3] = '{len: 59,   gaps: 1'b1, exp_wire_len: 64,   exp_drop: 1'b0};
        vecs[4] = '{len: 61,   gaps: 1'b1, exp_wire_len: 65,   exp_drop: 1'b0};
        vecs[5] = '{len: 100,  gaps: 1'b1, exp_wire_len: 104,  exp_drop: 1'b0};
        vecs[6] = '{len: 1514, gaps: 1'b0, exp_wire_len: 1518, exp_drop: 1'b0};
        vecs[7] = '{len: 1515, gaps: 1'b0, exp_wire_len: 0,    exp_drop: 1'b1};
        vecs[8] = '{len: 1600, gaps: 1'b1, exp_wire_len: 0,    exp_drop: 1'b1};

        u_if.s_valid = 1'b0;
        u_if.s_last  = 1'b0;
        u_if.s_data  = 8'h00;
        eth_ready    = 1'b1;
        ready_in     = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_s_ready", u_if.s_ready, 0);
        check_output("reset_sof", sof_in, 0);
        check_output("reset_eof", eof_in, 0);
        check_output("reset_data", data_in, 0);
        check_output("reset_busy", tx_busy, 0);
        check_output("reset_drop", frame_drop, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_output("s_ready_after_reset", u_if.s_ready, 1);
        @(posedge clk);
        #1;

        // Table of single frames
        foreach (vecs[i]) begin
            f0 = rx_frames;
            d0 = drops_seen;
            apply_stimulus(vecs[i].len, vecs[i].gaps);
            wait_idle();
            check_output("vec_frames", rx_frames - f0, vecs[i].exp_drop ? 0 : 1);
            check_output("vec_drops", drops_seen - d0, vecs[i].exp_drop ? 1 : 0);
            if (!vecs[i].exp_drop) begin
                check_output("vec_wire_len", last_rx.size(), vecs[i].exp_wire_len);
                check_output("vec_residue", residue_of_last(), RESIDUE);
            end
        end

        // Two queued 100-byte frames, then release the PCS
        ready_in = 1'b0;
        f0 = rx_frames;
        apply_stimulus(100, 1'b0);
        apply_stimulus(100, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check_output("held_by_ready_in", rx_frames - f0, 0);
        ready_in = 1'b1;
        wait_idle();
        check_output("two_frames_sent", rx_frames - f0, 2);
        check_output("back_to_back_gap", (last_gap >= IFG + 1), 1);

        // Oversize frame immediately followed by a 64-byte frame
        f0 = rx_frames;
        d0 = drops_seen;
        apply_stimulus(1600, 1'b0);
        apply_stimulus(64, 1'b0);
        wait_idle();
        check_output("oversize_drops", drops_seen - d0, 1);
        check_output("oversize_frames", rx_frames - f0, 1);
        check_output("after_drop_len", last_rx.size(), 68);

        // Link down holds a queued frame; start on the first ready_in after link up
        eth_ready = 1'b0;
        f0 = rx_frames;
        apply_stimulus(30, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        check_output("no_start_link_down", rx_frames - f0, 0);
        check_output("idle_link_down", tx_busy, 0);
        ready_in  = 1'b0;
        eth_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_output("no_sof_ready_in_low", sof_in, 0);
        end
        @(posedge clk);
        #1 ready_in = 1'b1;
        @(negedge clk);
        check_output("sof_first_ready", sof_in, 1);
        check_output("sof_head_byte", data_in, (exp_bytes.size() != 0) ? exp_bytes[0] : 9'h100);
        @(posedge clk);
        #1 eth_ready = 1'b0;
        wait_idle();
        check_output("link_drop_no_truncate", rx_frames - f0, 1);
        eth_ready = 1'b1;

        // Reset in the middle of a frame
        ready_in = 1'b0;
        f0 = rx_frames;
        apply_stimulus(100, 1'b0);
        ready_in = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(in_frame && cur.size() == 30) && n < 1000);
        check_output("reached_byte_30", cur.size(), 30);
        reset_n = 1'b0;
        #1;
        check_output("midreset_sof", sof_in, 0);
        check_output("midreset_eof", eof_in, 0);
        check_output("midreset_data", data_in, 0);
        check_output("midreset_busy", tx_busy, 0);
        check_output("midreset_s_ready", u_if.s_ready, 0);
        exp_lens.delete();
        exp_bytes.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_output("buffer_discarded", rx_frames - f0, 0);
        check_output("idle_after_reset", tx_busy, 0);
        apply_stimulus(20, 1'b1);
        wait_idle();
        check_output("frame_after_reset", rx_frames - f0, 1);

        // Randomized traffic with gaps and a random ready_in
        f0 = rx_frames;
        d0 = drops_seen;
        nf = 0;
        nd = 0;
        rand_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            len = ($urandom_range(7) == 0) ? $urandom_range(1600, 1515) : $urandom_range(150, 1);
            if (len > MAX_LEN) nd++;
            else nf++;
            apply_stimulus(len, 1'b1);
        end
        rand_ready = 1'b0;
        #2 ready_in = 1'b1;
        wait_idle();
        check_output("random_frames", rx_frames - f0, nf);
        check_output("random_drops", drops_seen - d0, nd);
        check_output("model_drained", exp_bytes.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
